// File: rtl/nanorv32_csr_access_pkg.sv
// nanorv32_csr_access_pkg
// Shared constants for the core-side CSR access sequencer: data/address widths,
// Zicsr funct3 encodings, access FSM states and the read-only CSR address field.
package nanorv32_csr_access_pkg;

  localparam int unsigned NANORV32_CSR_ADDR_MSB = 11;
  localparam int unsigned NANORV32_DATA_MSB     = 31;

  // Zicsr funct3 encodings. Bit 2 selects the immediate (zimm) operand form.
  localparam logic [2:0] NANORV32_CSR_FUNCT3_RW  = 3'b001;
  localparam logic [2:0] NANORV32_CSR_FUNCT3_RS  = 3'b010;
  localparam logic [2:0] NANORV32_CSR_FUNCT3_RC  = 3'b011;
  localparam logic [2:0] NANORV32_CSR_FUNCT3_RWI = 3'b101;
  localparam logic [2:0] NANORV32_CSR_FUNCT3_RSI = 3'b110;
  localparam logic [2:0] NANORV32_CSR_FUNCT3_RCI = 3'b111;

  // addr[11:10] == 2'b11 marks a read-only CSR.
  localparam logic [1:0] NANORV32_CSR_RO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } csr_acc_state_e;

  function automatic logic csr_addr_read_only(input logic [NANORV32_CSR_ADDR_MSB:0] addr);
    return addr[NANORV32_CSR_ADDR_MSB -: 2] == NANORV32_CSR_RO_FIELD;
  endfunction

endpackage

// File: rtl/nanorv32_csr_access_if.sv
// nanorv32_csr_access_if
// Core-to-CSR-file bus.
//   core_csr_addr  : CSR address (core -> CSR file)
//   core_csr_wdata : CSR write data (core -> CSR file)
//   core_csr_write : single-cycle write strobe (core -> CSR file)
//   csr_core_rdata : read data, combinational from core_csr_addr (CSR file -> core)
interface nanorv32_csr_access_if;
  import nanorv32_csr_access_pkg::*;

  logic [NANORV32_CSR_ADDR_MSB:0] core_csr_addr;
  logic [NANORV32_DATA_MSB:0]     core_csr_wdata;
  logic                           core_csr_write;
  logic [NANORV32_DATA_MSB:0]     csr_core_rdata;

  modport master (
    output core_csr_addr,
    output core_csr_wdata,
    output core_csr_write,
    input  csr_core_rdata
  );

  modport slave (
    input  core_csr_addr,
    input  core_csr_wdata,
    input  core_csr_write,
    output csr_core_rdata
  );

endinterface

// File: rtl/nanorv32_csr_access_alu.sv
// nanorv32_csr_access_alu
// Combinational read-modify-write datapath for Zicsr instructions.
//   op        : funct3[1:0] (the immediate/register distinction is resolved upstream)
//   old_val   : CSR value read in the RD phase
//   operand   : rs1 value or zero-extended zimm
//   rs1_zero  : rs1/zimm field was zero at accept
//   new_val   : value to write
//   write_en  : a write is attempted (set/clear with a zero field do not write)
//   op_legal  : funct3 is a defined CSR encoding
module nanorv32_csr_access_alu
  import nanorv32_csr_access_pkg::*;
(
  input  logic [1:0]                 op,
  input  logic [NANORV32_DATA_MSB:0] old_val,
  input  logic [NANORV32_DATA_MSB:0] operand,
  input  logic                       rs1_zero,
  output logic [NANORV32_DATA_MSB:0] new_val,
  output logic                       write_en,
  output logic                       op_legal
);

  always_comb begin
    new_val  = old_val;
    write_en = 1'b0;
    op_legal = 1'b1;
    unique case (op)
      NANORV32_CSR_FUNCT3_RW[1:0]: begin
        new_val  = operand;
        write_en = 1'b1;
      end
      NANORV32_CSR_FUNCT3_RS[1:0]: begin
        new_val  = old_val | operand;
        write_en = ~rs1_zero;
      end
      NANORV32_CSR_FUNCT3_RC[1:0]: begin
        new_val  = old_val & ~operand;
        write_en = ~rs1_zero;
      end
      // funct3 000 / 100
      default: op_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/nanorv32_csr_access.sv
// nanorv32_csr_access
// Core-side CSR initiator. Accepts a decoded Zicsr instruction, reads the CSR (RD),
// writes the modified value (WR), then presents the old value for rd writeback (DONE).
//   clk, rst_n          : clock, asynchronous active-low reset
//   csr_op_valid ...    : decoded instruction fields from EXE
//   csr_flush           : abort; honoured only in RD
//   stall_exe           : holds DONE (and its writeback outputs)
//   csr_bus             : CSR file bus (master side)
//   csr_busy            : pipeline stall request
//   csr_rd_we/idx/wdata : rd writeback
//   csr_illegal         : one-cycle illegal-instruction pulse in DONE
module nanorv32_csr_access
  import nanorv32_csr_access_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           csr_op_valid,
  input  logic [2:0]                     csr_funct3,
  input  logic [NANORV32_CSR_ADDR_MSB:0] csr_op_addr,
  input  logic [NANORV32_DATA_MSB:0]     csr_rs1_data,
  input  logic [4:0]                     csr_rs1_zimm,
  input  logic [4:0]                     csr_rd_idx,
  input  logic                           csr_flush,
  input  logic                           stall_exe,
  nanorv32_csr_access_if.master          csr_bus,
  output logic                           csr_busy,
  output logic                           csr_rd_we,
  output logic [4:0]                     csr_rd_idx_o,
  output logic [NANORV32_DATA_MSB:0]     csr_rd_wdata,
  output logic                           csr_illegal
);

  csr_acc_state_e                 state_q, state_d;
  logic [1:0]                     op_q;
  logic [NANORV32_CSR_ADDR_MSB:0] addr_q;
  logic [NANORV32_DATA_MSB:0]     operand_q;
  logic [NANORV32_DATA_MSB:0]     old_q;
  logic [4:0]                     rd_idx_q;
  logic                           rs1_zero_q;
  logic                           done_first_q;

  logic                           accept;
  logic [NANORV32_DATA_MSB:0]     operand_d;
  logic [NANORV32_DATA_MSB:0]     new_val;
  logic                           write_en;
  logic                           op_legal;
  logic                           illegal;
  logic                           do_write;

  assign accept    = (state_q == StIdle) && csr_op_valid;
  assign operand_d = csr_funct3[2] ? {{(NANORV32_DATA_MSB - 4){1'b0}}, csr_rs1_zimm}
                                   : csr_rs1_data;

  nanorv32_csr_access_alu u_alu (
    .op       (op_q),
    .old_val  (old_q),
    .operand  (operand_q),
    .rs1_zero (rs1_zero_q),
    .new_val  (new_val),
    .write_en (write_en),
    .op_legal (op_legal)
  );

  // Writes to read-only CSRs are illegal only when actually attempted, so
  // set/clear with a zero field may still read a read-only CSR.
  assign illegal  = ~op_legal || (write_en && csr_addr_read_only(addr_q));
  assign do_write = write_en && ~illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      addr_q       <= '0;
      operand_q    <= '0;
      old_q        <= '0;
      rd_idx_q     <= '0;
      rs1_zero_q   <= 1'b0;
      done_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_first_q <= (state_q == StWr);
      if (accept) begin
        op_q       <= csr_funct3[1:0];
        addr_q     <= csr_op_addr;
        operand_q  <= operand_d;
        rd_idx_q   <= csr_rd_idx;
        rs1_zero_q <= (csr_rs1_zimm == 5'd0);
      end
      if (state_q == StRd) begin
        old_q <= csr_bus.csr_core_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (csr_op_valid) state_d = StRd;
      StRd:   state_d = csr_flush ? StIdle : StWr;
      // Flush is ignored from WR on so the read-modify-write is atomic.
      StWr:   state_d = StDone;
      StDone: if (!stall_exe) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // All bus and writeback outputs decode from registered state only.
  always_comb begin
    csr_bus.core_csr_addr  = addr_q;
    csr_bus.core_csr_write = 1'b0;
    csr_bus.core_csr_wdata = '0;
    csr_busy               = accept || (state_q == StRd) || (state_q == StWr);
    csr_rd_we              = 1'b0;
    csr_rd_idx_o           = '0;
    csr_rd_wdata           = '0;
    csr_illegal            = 1'b0;
    if (state_q == StWr && do_write) begin
      csr_bus.core_csr_write = 1'b1;
      csr_bus.core_csr_wdata = new_val;
    end
    if (state_q == StDone) begin
      csr_rd_we    = (rd_idx_q != 5'd0) && ~illegal;
      csr_rd_idx_o = rd_idx_q;
      csr_rd_wdata = old_q;
      csr_illegal  = illegal && done_first_q;
    end
  end

endmodule

// File: tb/tb_nanorv32_csr_access.sv
module tb_nanorv32_csr_access;
  import nanorv32_csr_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        csr_op_valid;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_op_addr;
  logic [31:0] csr_rs1_data;
  logic [4:0]  csr_rs1_zimm;
  logic [4:0]  csr_rd_idx;
  logic        csr_flush;
  logic        stall_exe;
  logic        csr_busy;
  logic        csr_rd_we;
  logic [4:0]  csr_rd_idx_o;
  logic [31:0] csr_rd_wdata;
  logic        csr_illegal;
  logic [31:0] rdata_model;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        write;
    logic [31:0] wdata;
    logic        rd_we;
    logic [4:0]  rd_idx;
    logic [31:0] rd_wdata;
    logic        illegal;
  } exp_t;

  exp_t sb_q[$];

  localparam int ModeNormal  = 0;
  localparam int ModeFlushRd = 1;
  localparam int ModeFlushWr = 2;
  localparam int ModeResetWr = 3;

  always #5 clk = ~clk;

  nanorv32_csr_access_if bus ();
  assign bus.csr_core_rdata = rdata_model;

  nanorv32_csr_access u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .csr_op_valid (csr_op_valid),
    .csr_funct3   (csr_funct3),
    .csr_op_addr  (csr_op_addr),
    .csr_rs1_data (csr_rs1_data),
    .csr_rs1_zimm (csr_rs1_zimm),
    .csr_rd_idx   (csr_rd_idx),
    .csr_flush    (csr_flush),
    .stall_exe    (stall_exe),
    .csr_bus      (bus),
    .csr_busy     (csr_busy),
    .csr_rd_we    (csr_rd_we),
    .csr_rd_idx_o (csr_rd_idx_o),
    .csr_rd_wdata (csr_rd_wdata),
    .csr_illegal  (csr_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model of one CSR instruction.
  function automatic exp_t model(input logic [2:0] f3, input logic [11:0] addr,
                                 input logic [31:0] rs1d, input logic [4:0] zimm,
                                 input logic [4:0] rd, input logic [31:0] oldv);
    exp_t        e;
    logic [31:0] opnd;
    logic [31:0] nv;
    logic        attempt;
    logic        ill;
    opnd    = f3[2] ? {27'd0, zimm} : rs1d;
    nv      = 32'd0;
    attempt = 1'b0;
    if (f3 == 3'b001 || f3 == 3'b101) begin
      nv = opnd; attempt = 1'b1;
    end else if (f3 == 3'b010 || f3 == 3'b110) begin
      nv = oldv | opnd; attempt = (zimm != 5'd0);
    end else if (f3 == 3'b011 || f3 == 3'b111) begin
      nv = oldv & ~opnd; attempt = (zimm != 5'd0);
    end
    ill        = (f3 == 3'b000) || (f3 == 3'b100) || (attempt && addr[11:10] == 2'b11);
    e.write    = attempt && !ill;
    e.wdata    = e.write ? nv : 32'd0;
    e.rd_we    = (rd != 5'd0) && !ill;
    e.rd_idx   = rd;
    e.rd_wdata = oldv;
    e.illegal  = ill;
    return e;
  endfunction

  task automatic run_op(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1d,
                        input logic [4:0] zimm, input logic [4:0] rd, input logic [31:0] oldv,
                        input int mode, input int stall_n);
    exp_t e;
    sb_q.push_back(model(f3, addr, rs1d, zimm, rd, oldv));
    // Accept cycle
    @(negedge clk);
    csr_op_valid = 1'b1;
    csr_funct3   = f3;
    csr_op_addr  = addr;
    csr_rs1_data = rs1d;
    csr_rs1_zimm = zimm;
    csr_rd_idx   = rd;
    rdata_model  = oldv;
    #1;
    chk("busy_accept", 32'(csr_busy), 32'd1);
    // RD: scramble inputs so only captured values can be used
    @(negedge clk);
    csr_op_valid = 1'b0;
    csr_op_addr  = ~addr;
    csr_rs1_data = ~rs1d;
    csr_rs1_zimm = ~zimm;
    csr_rd_idx   = ~rd;
    #1;
    chk("busy_rd", 32'(csr_busy), 32'd1);
    chk("addr_rd", 32'(bus.core_csr_addr), 32'(addr));
    chk("write_rd", 32'(bus.core_csr_write), 32'd0);
    if (mode == ModeFlushRd) begin
      csr_flush = 1'b1;
      @(negedge clk);
      csr_flush = 1'b0;
      #1;
      e = sb_q.pop_front();
      chk("flush_rd_busy", 32'(csr_busy), 32'd0);
      chk("flush_rd_write", 32'(bus.core_csr_write), 32'd0);
      chk("flush_rd_rdwe", 32'(csr_rd_we), 32'd0);
      @(negedge clk);
      #1;
      chk("flush_rd_write2", 32'(bus.core_csr_write), 32'd0);
      chk("flush_rd_rdwe2", 32'(csr_rd_we), 32'd0);
      return;
    end
    // WR
    @(negedge clk);
    rdata_model = 32'hDEAD_BEEF;
    if (mode == ModeFlushWr) csr_flush = 1'b1;
    stall_exe = (stall_n > 0);
    #1;
    e = sb_q[0];
    chk("write_wr", 32'(bus.core_csr_write), 32'(e.write));
    chk("wdata_wr", bus.core_csr_wdata, e.wdata);
    chk("busy_wr", 32'(csr_busy), 32'd1);
    chk("rdwe_wr", 32'(csr_rd_we), 32'd0);
    if (mode == ModeResetWr) begin
      rst_n = 1'b0;
      #1;
      e = sb_q.pop_front();
      chk("rst_write", 32'(bus.core_csr_write), 32'd0);
      chk("rst_wdata", bus.core_csr_wdata, 32'd0);
      chk("rst_addr", 32'(bus.core_csr_addr), 32'd0);
      chk("rst_busy", 32'(csr_busy), 32'd0);
      chk("rst_rdwe", 32'(csr_rd_we), 32'd0);
      chk("rst_rdata", csr_rd_wdata, 32'd0);
      chk("rst_illegal", 32'(csr_illegal), 32'd0);
      stall_exe = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        chk("post_rst_write", 32'(bus.core_csr_write), 32'd0);
        chk("post_rst_rdwe", 32'(csr_rd_we), 32'd0);
      end
      return;
    end
    // DONE, first cycle: exactly three cycles after the accept cycle
    @(negedge clk);
    csr_flush = 1'b0;
    if (stall_n == 0) stall_exe = 1'b0;
    #1;
    e = sb_q.pop_front();
    chk("rdwe_done", 32'(csr_rd_we), 32'(e.rd_we));
    chk("rdidx_done", 32'(csr_rd_idx_o), 32'(e.rd_idx));
    chk("rdata_done", csr_rd_wdata, e.rd_wdata);
    chk("illegal_done", 32'(csr_illegal), 32'(e.illegal));
    chk("busy_done", 32'(csr_busy), 32'd0);
    chk("write_done", 32'(bus.core_csr_write), 32'd0);
    if (stall_n > 0) begin
      // A new op presented during DONE must not be accepted
      csr_op_valid = 1'b1;
      csr_op_addr  = 12'h7FF;
      csr_funct3   = 3'b001;
      #1;
      chk("busy_stall_valid", 32'(csr_busy), 32'd0);
    end
    for (int j = 1; j <= stall_n; j++) begin
      @(negedge clk);
      if (j == stall_n) begin
        stall_exe    = 1'b0;
        csr_op_valid = 1'b0;
      end
      #1;
      chk("rdwe_hold", 32'(csr_rd_we), 32'(e.rd_we));
      chk("rdata_hold", csr_rd_wdata, e.rd_wdata);
      chk("illegal_once", 32'(csr_illegal), 32'd0);
      chk("write_hold", 32'(bus.core_csr_write), 32'd0);
    end
    // Back in IDLE
    @(negedge clk);
    #1;
    chk("rdwe_idle", 32'(csr_rd_we), 32'd0);
    chk("illegal_idle", 32'(csr_illegal), 32'd0);
    chk("busy_idle", 32'(csr_busy), 32'd0);
    chk("addr_idle_hold", 32'(bus.core_csr_addr), 32'(addr));
  endtask

  initial begin
    rst_n        = 1'b0;
    csr_op_valid = 1'b0;
    csr_funct3   = 3'b000;
    csr_op_addr  = 12'h000;
    csr_rs1_data = 32'd0;
    csr_rs1_zimm = 5'd0;
    csr_rd_idx   = 5'd0;
    csr_flush    = 1'b0;
    stall_exe    = 1'b0;
    rdata_model  = 32'd0;
    #1;
    chk("reset_busy", 32'(csr_busy), 32'd0);
    chk("reset_write", 32'(bus.core_csr_write), 32'd0);
    chk("reset_addr", 32'(bus.core_csr_addr), 32'd0);
    chk("reset_rdwe", 32'(csr_rd_we), 32'd0);
    chk("reset_illegal", 32'(csr_illegal), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // CSRRW to read-only 0xC00: illegal
    run_op(3'b001, 12'hC00, 32'h0000_0055, 5'd5, 5'd1, 32'h0000_0099, ModeNormal, 0);
    // CSRRS 0xC00 with x0: read-only read is legal
    run_op(3'b010, 12'hC00, 32'h0000_0000, 5'd0, 5'd3, 32'h0000_1234, ModeNormal, 0);
    // CSRRC 0x340
    run_op(3'b011, 12'h340, 32'h0000_00F0, 5'd6, 5'd4, 32'hFFFF_00FF, ModeNormal, 0);
    // CSRRSI zimm=5
    run_op(3'b110, 12'h340, 32'h0, 5'd5, 5'd7, 32'h0000_0010, ModeNormal, 0);
    // CSRRWI zimm=0: write of 0 still issued
    run_op(3'b101, 12'h340, 32'hFFFF_FFFF, 5'd0, 5'd8, 32'h0000_ABCD, ModeNormal, 0);
    // CSRRCI zimm=0: suppressed
    run_op(3'b111, 12'h341, 32'h0, 5'd0, 5'd9, 32'h0000_0F0F, ModeNormal, 0);
    // funct3 100: illegal, rd=0
    run_op(3'b100, 12'h300, 32'h1, 5'd1, 5'd0, 32'h0000_0001, ModeNormal, 0);
    // Flush in RD, then flush in WR
    run_op(3'b001, 12'h340, 32'hCAFE_0001, 5'd2, 5'd10, 32'h0000_0002, ModeFlushRd, 0);
    run_op(3'b001, 12'h340, 32'hCAFE_0002, 5'd2, 5'd11, 32'h0000_0003, ModeFlushWr, 0);
    // Held DONE for 4 stall cycles
    run_op(3'b010, 12'h305, 32'h0000_0100, 5'd12, 5'd12, 32'h8000_0000, ModeNormal, 4);
    // Reset during WR
    run_op(3'b001, 12'h340, 32'h1357_9BDF, 5'd3, 5'd13, 32'h0000_0004, ModeResetWr, 0);
    // Normal op after reset
    run_op(3'b001, 12'h342, 32'h2468_ACE0, 5'd3, 5'd14, 32'h0000_0005, ModeNormal, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nanorv32_csr_access.md
Name: nanorv32_csr_access

Overview:
Core-side initiator for the CSR interface. It takes decoded Zicsr instructions (CSRRW/RS/RC and the immediate forms) and performs a sequenced read-modify-write on the CSR file through core_csr_addr, core_csr_wdata and core_csr_write, reading csr_core_rdata. It returns the old CSR value for rd writeback, and stalls the pipeline while the access is in flight. It also flags illegal CSR instructions.

Parameters:
NANORV32_CSR_ADDR_MSB, 11, MSB of CSR address.
NANORV32_DATA_MSB, 31, MSB of data word.

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
csr_op_valid  in  1  decoded CSR instruction present in EXE
csr_funct3  in  3  instruction funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
csr_op_addr  in  12  instruction CSR address
csr_rs1_data  in  32  rs1 register value
csr_rs1_zimm  in  5  rs1 field: register index, or zimm for the immediate forms
csr_rd_idx  in  5  destination register index
csr_flush  in  1  pipeline flush (abort)
stall_exe  in  1  downstream hold
core_csr_addr  out  12  CSR address to the CSR file
core_csr_wdata  out  32  CSR write data
core_csr_write  out  1  CSR write strobe, one cycle
csr_core_rdata  in  32  CSR read data (combinational from core_csr_addr)
csr_busy  out  1  stall request to the pipeline
csr_rd_we  out  1  rd writeback valid
csr_rd_idx_o  out  5  rd index for the writeback
csr_rd_wdata  out  32  old CSR value
csr_illegal  out  1  illegal-instruction pulse

Behaviour:
- Reset values: all outputs are 0; the FSM is in IDLE; captured registers are 0.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - csr_op_valid=1 captures funct3, addr, operand, rd_idx and moves to RD.
  - Operand is zero-extended csr_rs1_zimm when funct3[2]=1, else csr_rs1_data.
  - csr_busy=1 combinationally in the accept cycle.
- RD:
  - core_csr_addr = captured addr.
  - Registers old_r <= csr_core_rdata.
  - Goes to WR. If csr_flush=1, goes to IDLE instead, with no write and no rd_we.
- WR:
  - new = operand for RW; old_r | operand for RS; old_r & ~operand for RC.
  - core_csr_write=1 for exactly this cycle, with core_csr_wdata=new, unless the write is suppressed.
  - Suppression: RS/RC/RSI/RCI with csr_rs1_zimm==0 do not write.
  - Goes to DONE. csr_flush is ignored from WR onward, so the write is atomic.
- DONE:
  - csr_rd_we=1 if rd_idx!=0 and the access is legal; csr_rd_wdata=old_r; csr_rd_idx_o=rd_idx.
  - Stays in DONE (outputs held) while stall_exe=1.
  - Goes to IDLE when stall_exe=0.
- csr_busy=1 in the accept cycle, RD and WR; 0 in DONE and IDLE.
- Latency: accept to rd_we is 3 cycles minimum. A new op cannot be accepted until the FSM is back in IDLE.
- Illegal cases: funct3 of 000 or 100; or an attempted write (not suppressed) to addr[11:10]==2'b11 (read-only).
  - The FSM still traverses RD/WR/DONE.
  - core_csr_write is forced to 0 and csr_rd_we to 0.
  - csr_illegal=1 for the first DONE cycle only.
- core_csr_addr holds the last captured address in IDLE. There are no glitching writes: core_csr_write is only ever driven from a registered state decode.
- Reset mid-operation returns to IDLE immediately with all outputs at 0. No partial write is issued after reset release.
- Widths: all arithmetic is 32 bit, with no carries; zimm is zero-extended to 32 bits.

Decomposition:
- Shared parameters file (nanorv32_parameters.v) gains:
  - CSR funct3 encodings: NANORV32_CSR_FUNCT3_RW/RS/RC/RWI/RSI/RCI.
  - FSM state encodings: NANORV32_CSR_ACC_IDLE/RD/WR/DONE.
  - Read-only address field constant: addr[11:10]==2'b11.
- Optional combinational sub-module nanorv32_csr_alu: takes funct3, old value and operand; produces new value and write-enable. Everything else stays in one module.

Test Plan:
- CSRRW addr 0xC00 (read-only cycle), rs1=x5 -> illegal; csr_illegal pulses one cycle; core_csr_write never 1; csr_rd_we=0.
- CSRRS addr 0xC00 with rs1 index 0, rd=x3, cycle counter=0x1234 in RD -> no write strobe; csr_rd_we=1, rd_idx_o=3, rd_wdata=0x00001234 exactly 3 cycles after accept.
- CSRRC on writable addr 0x340, CSR rdata=0xFFFF00FF, rs1_data=0x000000F0 -> core_csr_write=1 for one cycle with wdata=0xFFFF000F; rd_wdata=0xFFFF00FF.
- CSRRSI zimm=5 on 0x340, rdata=0x10 -> wdata=0x15; CSRRWI zimm=0 -> write of 0x0 issued (not suppressed).
- csr_flush asserted in RD -> back to IDLE next cycle; no write, no rd_we. Repeat with flush in WR -> write still occurs.
- stall_exe=1 for 4 cycles in DONE -> rd_we and rd_wdata held stable for 5 cycles; new op accepted only after release. Assert rst_n=0 during WR -> all outputs 0 immediately.
